display_arbiter: RTL
====================

# display_arbiter

Display scheduler that sits in front of `multiseg_driver` and owns its `bcd_in` bus. It shares the single 4-digit seven-segment display between two binary-valued requesters using round-robin arbitration with a valid/ready handshake. It converts each accepted 14-bit binary value to packed 4-digit BCD with a sequential shift-add-3 (double-dabble) engine, then holds the result on the display for a minimum dwell time before it grants another request.

## Interface
Parameters:
- `HOLD_CYCLES`, default 50_000_000: minimum dwell in HOLD, in clk cycles, before the next grant. Legal range is ≥1. Benches use 8.

Ports:
- `clk` in 1: system clock; all state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req0_valid` in 1: requester 0 has a value to show.
- `req0_data` in 14: requester 0 unsigned binary value.
- `req0_ready` out 1: requester 0 is granted this cycle.
- `req1_valid` in 1: requester 1 has a value to show.
- `req1_data` in 14: requester 1 unsigned binary value.
- `req1_ready` out 1: requester 1 is granted this cycle.
- `bcd_out` out 16: packed BCD to `multiseg_driver.bcd_in`. Bits [15:12] are the thousands digit and bits [3:0] are the units digit.
- `owner` out 1: index of the requester whose value is currently in `bcd_out`.
- `busy` out 1: high whenever the state is not IDLE.
- `sat` out 1: the last accepted value exceeded 9999 and was clamped.

## Operation
- The FSM has three states: IDLE, CONV, HOLD. Reset enters IDLE.
- **IDLE:** `readyN` is combinational and equals IDLE AND grant==N. Only one ready may be high in any cycle.
  - If only one valid is high, that requester is granted.
  - If both valids are high, grant the requester that is not `last_owner`.
  - A handshake is a cycle in which `validN && readyN` is high. On the handshake edge:
    - capture the data, clamped so that any value >9999 becomes 9999;
    - set `sat` = (raw data >9999);
    - set `last_owner` = N;
    - clear the shift counter;
    - go to CONV.
  - With no valid high, stay in IDLE.
- **CONV:** performs exactly 14 iterations, one per cycle, on a 30-bit register {16-bit BCD, 14-bit binary}.
  - Each iteration adds 3 to every BCD nibble ≥5, then shifts left by 1.
  - On the 14th iteration edge: load `bcd_out` with the upper 16 bits, set `owner` = `last_owner`, load the hold counter, and go to HOLD.
  - `bcd_out` never shows partial results.
- **HOLD:** the counter decrements each cycle. The state returns to IDLE on the edge where the counter reaches 0, giving exactly `HOLD_CYCLES` cycles in HOLD. `bcd_out` is stable throughout.
- Requesters may assert or deassert `valid` at any time. The arbiter samples only in IDLE. `data` must be stable only in the handshake cycle.
- The arbiter never drops or duplicates a value: one handshake produces exactly one `bcd_out` update.
- Identical successive values still pass through CONV and HOLD.
- **Reset mid-operation:** any in-progress conversion or hold is aborted. No update is produced and no partial value appears.
- **Reset values:**
  - state IDLE;
  - `bcd_out` 16'h0000;
  - `owner` 0;
  - `last_owner` 1, so req0 wins the first tie;
  - `sat` 0;
  - `busy` 0;
  - both ready signals 0 during the reset cycle.

## Timing
- The handshake is at edge k, with IDLE in the cycle before edge k.
- CONV occupies cycles k..k+13.
- `bcd_out`, `owner` and the entry into HOLD update at edge k+14.
- HOLD occupies cycles k+14 .. k+13+`HOLD_CYCLES`, and IDLE is re-entered at edge k+14+`HOLD_CYCLES`.
- The earliest next handshake edge is k+15+`HOLD_CYCLES`. Minimum grant spacing is therefore 15+`HOLD_CYCLES` cycles.
- `busy` rises at edge k and falls at edge k+14+`HOLD_CYCLES`.
- `sat` updates at the handshake edge and holds until the next handshake or reset.
- There is no combinational path from `reqN_data` to any output.

## Test plan
- **Reset then single request.** Drive req0_valid=1, req0_data=14'd1234, HOLD_CYCLES=8. Required: req0_ready high in the first IDLE cycle; bcd_out=16'h1234 exactly 14 cycles after the handshake; owner=0; sat=0; next grant possible 23 cycles after the handshake.
- **Clamp.** req1_data=14'd16383 produces bcd_out=16'h9999 and sat=1. A following req1_data=0 produces bcd_out=16'h0000 and sat=0.
- **Conversion sweep.** Send values 0, 9, 10, 99, 100, 999, 1000, 5005, 9999 and compare bcd_out against a reference model. This covers nibble-carry boundaries.
- **Round-robin fairness.** Hold both valids high continuously with req0_data=11 and req1_data=22. Grants must alternate 0,1,0,1 with req0 first after reset, and bcd_out must alternate 16'h0011/16'h0022 at a spacing of 23 cycles.
- **Handshake discipline.** Deassert req1_valid during HOLD and assert req0_valid during CONV. Required: ready stays low outside IDLE, the req0 grant happens only on the IDLE cycle, and no ready ever coincides with busy=1.
- **Reset mid-operation.** Assert rst on CONV cycle 7 after a request for 4321. Required: bcd_out=0, busy=0, and no 16'h4321 ever appears. A new request for 4321 then converts normally.

Source files
------------

// File: rtl/display_arbiter.sv
// Round-robin scheduler for two binary requesters sharing one 4-digit BCD display.
// Each grant converts the value with a 14-step double-dabble engine, then holds it for HOLD_CYCLES.
module display_arbiter #(
    parameter int HOLD_CYCLES = 50_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    input  logic [13:0] req0_data,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [13:0] req1_data,
    output logic        req1_ready,
    output logic [15:0] bcd_out,
    output logic        owner,
    output logic        busy,
    output logic        sat,
    output logic [1:0]  dbg_state
);

    // Handshake: a value is accepted on a rising edge where reqN_valid && reqN_ready.
    // ready is only ever high in IDLE, for at most one requester, and never during rst.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        HOLD = 2'd2
    } state_e;

    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);
    localparam logic [13:0] BCD_MAX = 14'd9999;
    localparam logic [3:0] LAST_ITER = 4'd13;

    state_e        state_q, state_d;
    logic [29:0]   shift_q, shift_d;
    logic [3:0]    iter_q, iter_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [15:0]   bcd_q, bcd_d;
    logic          owner_q, owner_d;
    logic          last_q, last_d;
    logic          sat_q, sat_d;

    logic          grant0, grant1;
    logic          is_idle;
    logic [13:0]   raw_data;
    logic [29:0]   shift_nx;

    function automatic logic [29:0] dd_step(input logic [29:0] x);
        logic [29:0] y;
        y = x;
        for (int i = 0; i < 4; i++) begin
            if (y[14+4*i +: 4] >= 4'd5) begin
                y[14+4*i +: 4] = y[14+4*i +: 4] + 4'd3;
            end
        end
        return {y[28:0], 1'b0};
    endfunction

    // On a tie the requester that did not show last wins.
    assign grant0     = req0_valid && (!req1_valid || last_q);
    assign grant1     = req1_valid && (!req0_valid || !last_q);
    assign is_idle    = (state_q == IDLE);
    assign req0_ready = is_idle && !rst && grant0;
    assign req1_ready = is_idle && !rst && grant1;

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        iter_d   = iter_q;
        hold_d   = hold_q;
        bcd_d    = bcd_q;
        owner_d  = owner_q;
        last_d   = last_q;
        sat_d    = sat_q;
        raw_data = req1_ready ? req1_data : req0_data;
        shift_nx = dd_step(shift_q);

        case (state_q)
            IDLE: begin
                if (req0_ready || req1_ready) begin
                    sat_d   = (raw_data > BCD_MAX);
                    shift_d = {16'h0000, (raw_data > BCD_MAX) ? BCD_MAX : raw_data};
                    last_d  = req1_ready;
                    iter_d  = 4'd0;
                    state_d = CONV;
                end
            end
            CONV: begin
                shift_d = shift_nx;
                iter_d  = iter_q + 4'd1;
                // Only the finished conversion reaches the display register.
                if (iter_q == LAST_ITER) begin
                    bcd_d   = shift_nx[29:14];
                    owner_d = last_q;
                    hold_d  = HOLD_LOAD;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (hold_q == '0) begin
                    state_d = IDLE;
                end else begin
                    hold_d = hold_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            iter_q  <= '0;
            hold_q  <= '0;
            bcd_q   <= 16'h0000;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            iter_q  <= iter_d;
            hold_q  <= hold_d;
            bcd_q   <= bcd_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            sat_q   <= sat_d;
        end
    end

    assign bcd_out   = bcd_q;
    assign owner     = owner_q;
    assign sat       = sat_q;
    assign busy      = !is_idle;
    assign dbg_state = state_q;

endmodule
